sonic_tx_arbiter: RTL and testbench
===================================

// Module: sonic_tx_arbiter
// PURPOSE
//  Shares the single PCIe Avalon-ST TX descriptor/data port among NUM_REQ requesters
//  (IRQ generator, DMA write and DMA read engines) using the sel/busy/ready handshake.
//  Grants one requester at a time, round-robin, and muxes its TX signals to the PCIe core.
//  Sits between the requester blocks and the PCIe hard-IP TX interface in the chaining DMA top.
// PARAMETERS
//  NUM_REQ        4     number of requesters (2..8); index 0 is the IRQ generator
//  GRANT_TIMEOUT  255   cycles a grant waits for busy before it is revoked (1..65535)
// PORTS
//  clk_in          in   1            core clock
//  rstn            in   1            async active-low reset
//  req_ready       in   NUM_REQ      requester i wants the port
//  req_busy        in   NUM_REQ      requester i is mid-transfer
//  req_sel         out  NUM_REQ      one-hot grant
//  req_ready_others out NUM_REQ      bit i = OR of req_ready excluding bit i
//  req_tx_req      in   NUM_REQ      per-requester tx_req
//  req_tx_desc     in   NUM_REQ*128  per-requester descriptor, requester i at [128*i +: 128]
//  req_tx_dfr/dv/err in NUM_REQ      per-requester dfr, dv, err
//  req_tx_data     in   NUM_REQ*128  per-requester data, requester i at [128*i +: 128]
//  req_tx_ack      out  NUM_REQ      tx_ack routed to the granted requester only
//  req_tx_ws       out  1            tx_ws broadcast
//  tx_req/tx_dfr/tx_dv/tx_err  out 1  to PCIe core
//  tx_desc, tx_data  out 128          to PCIe core
//  tx_ack, tx_ws     in  1            from PCIe core
//  timeout_cnt     out  16           saturating count of revoked grants
// BEHAVIOUR
//  - Reset: state=IDLE, req_sel=0, last_grant=NUM_REQ-1 (req 0 wins first), timer=0,
//    timeout_cnt=0. All tx_* outputs are 0 because the mux is gated by sel=0.
//  - States:
//    - IDLE: if any req_ready, pick the first ready index after last_grant (modulo NUM_REQ).
//      req_sel is registered, so ready seen at edge N gives sel high from N+1. Next state GRANT.
//    - GRANT: if req_busy[g]=1, go to BUSY and clear the timer.
//      Else if req_ready[g]=0 (withdrawn), go to IDLE and clear sel.
//      Else timer++; when timer==GRANT_TIMEOUT, go to IDLE, clear sel,
//      timeout_cnt++ (saturates at 0xFFFF).
//    - BUSY: hold sel with no timeout. A grant is never revoked mid-transfer.
//      When req_busy[g]=0, go to IDLE, clear sel, last_grant=g.
//  - After every grant ends, at least 1 IDLE bubble cycle separates consecutive grants.
//  - Mux (combinational from registered sel):
//    - tx_* = fields of the granted requester, or all 0 when sel=0.
//    - req_tx_ack[i] = tx_ack & sel[i]; req_tx_ws = tx_ws.
//  - req_busy of non-granted requesters is ignored.
//  - req_ready_others is combinational and independent of state.
//  - Timeout and withdraw both leave last_grant unchanged, so the same requester may win again
//    if it is still first in order.
//  - rstn asserted mid-transfer: immediate return to reset values; the in-flight TLP is dropped.
// CONFIGURATION
//  SONIC_TX_ARB_PRIO_EN defined:
//    - In IDLE, req_ready[0] (IRQ) wins over all others regardless of last_grant.
//    - Other requesters stay round-robin among themselves.
//  Not defined: pure round-robin for all requesters, including index 0.
// TESTING
//  1. Reset then req_ready=4'b0100 -> req_sel=4'b0100 exactly 1 cycle later; tx_desc = req 2 desc.
//  2. req_ready=4'b1111 held, each requester pulses busy for 3 cycles ->
//     grant order 0,1,2,3,0, with 1 idle cycle between grants.
//  3. Grant to req 1, busy never asserted, GRANT_TIMEOUT=255 -> sel cleared 255 cycles after
//     grant, timeout_cnt=1.
//  4. tx_ack pulse during grant to req 3 -> req_tx_ack=4'b1000 only; tx_ws=1 seen on req_tx_ws.
//  5. PRIO_EN defined, last_grant=0, req_ready=4'b0011 -> req 0 granted again.
//     Without PRIO_EN -> req 1 granted.
//  6. rstn low during BUSY -> req_sel=0, tx_req=0 the same cycle; after release req 0 wins first.

Source files
------------

// File: rtl/sonic_tx_arbiter_if.sv
// Bundle of requester-side and PCIe-core-side TX signals for sonic_tx_arbiter.
// Handshake: a requester raises ready to ask for the port; the arbiter answers with a registered
// one-hot sel; the requester holds busy while its TLP is in flight and drops it to release sel.
interface sonic_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ-1:0]     req_busy;
  logic [NUM_REQ-1:0]     req_sel;
  logic [NUM_REQ-1:0]     req_ready_others;
  logic [NUM_REQ-1:0]     req_tx_req;
  logic [NUM_REQ*128-1:0] req_tx_desc;
  logic [NUM_REQ-1:0]     req_tx_dfr;
  logic [NUM_REQ-1:0]     req_tx_dv;
  logic [NUM_REQ-1:0]     req_tx_err;
  logic [NUM_REQ*128-1:0] req_tx_data;
  logic [NUM_REQ-1:0]     req_tx_ack;
  logic                   req_tx_ws;
  logic                   tx_req;
  logic                   tx_dfr;
  logic                   tx_dv;
  logic                   tx_err;
  logic [127:0]           tx_desc;
  logic [127:0]           tx_data;
  logic                   tx_ack;
  logic                   tx_ws;

  modport master (
    input  req_ready, req_busy, req_tx_req, req_tx_desc, req_tx_dfr, req_tx_dv, req_tx_err,
           req_tx_data, tx_ack, tx_ws,
    output req_sel, req_ready_others, req_tx_ack, req_tx_ws, tx_req, tx_dfr, tx_dv, tx_err,
           tx_desc, tx_data
  );

  modport slave (
    output req_ready, req_busy, req_tx_req, req_tx_desc, req_tx_dfr, req_tx_dv, req_tx_err,
           req_tx_data, tx_ack, tx_ws,
    input  req_sel, req_ready_others, req_tx_ack, req_tx_ws, tx_req, tx_dfr, tx_dv, tx_err,
           tx_desc, tx_data
  );
endinterface

// File: rtl/sonic_tx_arbiter.sv
// Round-robin arbiter sharing the PCIe TX port among NUM_REQ requesters, with grant timeout.
// Define SONIC_TX_ARB_PRIO_EN to give requester 0 (IRQ) absolute priority in IDLE.
module sonic_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GRANT_TIMEOUT = 255
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  sonic_tx_arbiter_if.master   bus,
  output logic [15:0]          timeout_cnt,
  output logic [1:0]           state_dbg
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMER_LAST = 16'(GRANT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [15:0]        timer_q, timer_d;
  logic [15:0]        tcnt_q, tcnt_d;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  // Scan from the farthest candidate to the nearest so the first ready index after last_q wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (bus.req_ready[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
`ifdef SONIC_TX_ARB_PRIO_EN
    if (bus.req_ready[0]) begin
      pick_found = 1'b1;
      pick_idx   = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = NUM_REQ'(1) << pick_idx;
          grant_d = pick_idx;
          timer_d = '0;
        end
      end
      GRANT: begin
        if (bus.req_busy[grant_q]) begin
          state_d = BUSY;
          timer_d = '0;
        end else if (!bus.req_ready[grant_q]) begin
          state_d = IDLE;
          sel_d   = '0;
        end else if (timer_q == TIMER_LAST) begin
          state_d = IDLE;
          sel_d   = '0;
          timer_d = '0;
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      BUSY: begin
        // No timeout here: a transfer in flight is never cut short.
        if (!bus.req_busy[grant_q]) begin
          state_d = IDLE;
          sel_d   = '0;
          last_d  = grant_q;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      timer_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      tcnt_q  <= tcnt_d;
    end
  end

  logic               mux_req, mux_dfr, mux_dv, mux_err;
  logic [127:0]       mux_desc, mux_data;
  logic [NUM_REQ-1:0] others;

  // sel is one-hot or zero, so OR-ing the gated fields gives a clean mux that idles at 0.
  always_comb begin
    mux_req  = 1'b0;
    mux_dfr  = 1'b0;
    mux_dv   = 1'b0;
    mux_err  = 1'b0;
    mux_desc = '0;
    mux_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_q[i]) begin
        mux_req  = mux_req  | bus.req_tx_req[i];
        mux_dfr  = mux_dfr  | bus.req_tx_dfr[i];
        mux_dv   = mux_dv   | bus.req_tx_dv[i];
        mux_err  = mux_err  | bus.req_tx_err[i];
        mux_desc = mux_desc | bus.req_tx_desc[128*i +: 128];
        mux_data = mux_data | bus.req_tx_data[128*i +: 128];
      end
    end
  end

  always_comb begin
    others = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      others[i] = |(bus.req_ready & ~(NUM_REQ'(1) << i));
    end
  end

  assign bus.tx_req           = mux_req;
  assign bus.tx_dfr           = mux_dfr;
  assign bus.tx_dv            = mux_dv;
  assign bus.tx_err           = mux_err;
  assign bus.tx_desc          = mux_desc;
  assign bus.tx_data          = mux_data;
  assign bus.req_sel          = sel_q;
  assign bus.req_tx_ack       = sel_q & {NUM_REQ{bus.tx_ack}};
  assign bus.req_tx_ws        = bus.tx_ws;
  assign bus.req_ready_others = others;
  assign timeout_cnt          = tcnt_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_sonic_tx_arbiter.sv
// Bench for sonic_tx_arbiter: directed scenarios plus randomized traffic against a grant-owner model.
module tb_sonic_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 255;
`ifdef SONIC_TX_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rstn   = 1'b0;
  logic [15:0] timeout_cnt;
  logic [1:0]  state_dbg;

  sonic_tx_arbiter_if #(.NUM_REQ(N)) bus();

  sonic_tx_arbiter #(.NUM_REQ(N), .GRANT_TIMEOUT(TMO)) dut (
    .clk_in      (clk_in),
    .rstn        (rstn),
    .bus         (bus),
    .timeout_cnt (timeout_cnt),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_sel;

  logic [127:0] desc [N];
  logic [127:0] data [N];
  logic [N-1:0] t_req, t_dfr, t_dv, t_err;

  // model: who owns the port, whether its transfer started, cycles waited, rotation pointer
  int m_owner;
  bit m_xfer;
  int m_wait;
  int m_last;
  int m_revokes;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_tx_desc[128*i +: 128] = desc[i];
      bus.req_tx_data[128*i +: 128] = data[i];
    end
    bus.req_tx_req = t_req;
    bus.req_tx_dfr = t_dfr;
    bus.req_tx_dv  = t_dv;
    bus.req_tx_err = t_err;
  endtask

  task automatic shuffle_fields();
    for (int i = 0; i < N; i++) begin
      desc[i] = {$urandom, $urandom, $urandom, $urandom};
      data[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    t_req = N'($urandom_range(0, 15));
    t_dfr = N'($urandom_range(0, 15));
    t_dv  = N'($urandom_range(0, 15));
    t_err = N'($urandom_range(0, 15));
    drive_fields();
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_xfer    = 1'b0;
    m_wait    = 0;
    m_last    = N - 1;
    m_revokes = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] r, b;
    int pick;
    r    = bus.req_ready;
    b    = bus.req_busy;
    pick = -1;
    if (m_owner < 0) begin
      if (PRIO && r[0]) pick = 0;
      else
        for (int k = 1; k <= N; k++)
          if (pick < 0 && r[(m_last + k) % N]) pick = (m_last + k) % N;
      if (pick >= 0) begin
        m_owner = pick;
        m_xfer  = 1'b0;
        m_wait  = 0;
      end
    end else if (m_xfer) begin
      if (!b[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (b[m_owner]) begin
      m_xfer = 1'b1;
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else begin
      m_wait++;
      if (m_wait == TMO) begin
        m_owner = -1;
        if (m_revokes < 65535) m_revokes++;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_others;
    logic [127:0] e_desc, e_data;
    logic [3:0]   e_ctl;
    for (int i = 0; i < N; i++) e_others[i] = ((bus.req_ready & ~onehot(i)) != 0);
    if (m_owner >= 0) begin
      e_desc = desc[m_owner];
      e_data = data[m_owner];
      e_ctl  = {t_req[m_owner], t_dfr[m_owner], t_dv[m_owner], t_err[m_owner]};
    end else begin
      e_desc = '0;
      e_data = '0;
      e_ctl  = '0;
    end
    check("sel", bus.req_sel, onehot(m_owner));
    check("timeout_cnt", timeout_cnt, m_revokes);
    check("tx_desc", bus.tx_desc, e_desc);
    check("tx_data", bus.tx_data, e_data);
    check("tx_ctl", {bus.tx_req, bus.tx_dfr, bus.tx_dv, bus.tx_err}, e_ctl);
    check("tx_ack", bus.req_tx_ack, bus.tx_ack ? onehot(m_owner) : '0);
    check("tx_ws", bus.req_tx_ws, bus.tx_ws);
    check("ready_others", bus.req_ready_others, e_others);
  endtask

  task automatic step();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic apply_reset();
    bus.req_ready = '0;
    bus.req_busy  = '0;
    bus.tx_ack    = 1'b0;
    bus.tx_ws     = 1'b0;
    rstn          = 1'b0;
    repeat (2) @(negedge clk_in);
    model_reset();
    check("rst_sel", bus.req_sel, '0);
    check("rst_tcnt", timeout_cnt, 16'd0);
    check("rst_tx_req", bus.tx_req, 1'b0);
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int bown, bcnt, grants, zero_run, hi;

  initial begin
    shuffle_fields();
    apply_reset();

    // single ready -> sel one cycle later, descriptor routed
    bus.req_ready = 4'b0100;
    #1 check("t1_sel_pre", bus.req_sel, 4'b0000);
    step();
    check("t1_sel", bus.req_sel, 4'b0100);
    check("t1_desc", bus.tx_desc, desc[2]);
    bus.req_ready = '0;
    step();

    // all ready, 3-cycle busy per grant -> 0,1,2,3,0 with one idle bubble each
    apply_reset();
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req_ready = 4'b1111;
    bown = -1; bcnt = 0; grants = 0; zero_run = 0;
    for (int cyc = 0; cyc < 200 && grants < 5; cyc++) begin
      step();
      if (bus.req_sel != 0 && bown < 0) begin
        exp_sel = exp_q.pop_front();
        check("t2_order", bus.req_sel, exp_sel);
        if (grants > 0) check("t2_gap", zero_run, 1);
        zero_run = 0;
        grants++;
        for (int i = 0; i < N; i++) if (bus.req_sel[i]) bown = i;
        bcnt = 3;
        bus.req_busy = onehot(bown);
      end else if (bown >= 0) begin
        bcnt--;
        if (bcnt == 0) begin
          bus.req_busy = '0;
          bown = -1;
        end
      end else if (bus.req_sel == 0) begin
        zero_run++;
      end
    end
    check("t2_grants", grants, 5);
    bus.req_ready = '0;
    bus.req_busy  = '0;
    repeat (4) step();

    // grant without busy is revoked after GRANT_TIMEOUT cycles
    apply_reset();
    bus.req_ready = 4'b0010;
    step();
    check("t3_sel", bus.req_sel, 4'b0010);
    hi = 1;
    while (bus.req_sel == 4'b0010 && hi < 400) begin
      step();
      if (bus.req_sel == 4'b0010) hi++;
    end
    check("t3_hold", hi, TMO);
    check("t3_tcnt", timeout_cnt, 16'd1);
    bus.req_ready = '0;
    step();

    // ack routed only to the granted requester, ws broadcast
    apply_reset();
    bus.req_ready = 4'b1000;
    step();
    bus.tx_ack = 1'b1;
    bus.tx_ws  = 1'b1;
    #1;
    check("t4_ack", bus.req_tx_ack, 4'b1000);
    check("t4_ws", bus.req_tx_ws, 1'b1);
    step();
    bus.tx_ack = 1'b0;
    bus.tx_ws  = 1'b0;
    bus.req_ready = '0;
    step();

    // after a completed grant to req 0, ready=0011 picks 0 with priority, 1 without
    apply_reset();
    bus.req_ready = 4'b0001;
    step();
    bus.req_busy = 4'b0001;
    step();
    bus.req_busy = '0;
    step();
    check("t5_idle", bus.req_sel, 4'b0000);
    bus.req_ready = 4'b0011;
    step();
    check("t5_sel", bus.req_sel, PRIO ? 4'b0001 : 4'b0010);
    bus.req_ready = '0;
    repeat (3) step();

    // async reset during BUSY clears sel and the mux immediately
    apply_reset();
    t_req = 4'b0100;
    drive_fields();
    bus.req_ready = 4'b0100;
    step();
    bus.req_busy = 4'b0100;
    step();
    check("t6_busy_txreq", bus.tx_req, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_sel", bus.req_sel, 4'b0000);
    check("t6_rst_txreq", bus.tx_req, 1'b0);
    model_reset();
    bus.req_busy  = '0;
    bus.req_ready = 4'b1111;
    @(negedge clk_in);
    rstn = 1'b1;
    step();
    check("t6_first", bus.req_sel, 4'b0001);
    bus.req_ready = '0;
    repeat (3) step();

    // random traffic: busy toggles often
    apply_reset();
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) bus.req_ready[i] = ~bus.req_ready[i];
        if ($urandom_range(0, 5) == 0)  bus.req_busy[i]  = ~bus.req_busy[i];
      end
      bus.tx_ack = 1'($urandom_range(0, 1));
      bus.tx_ws  = 1'($urandom_range(0, 1));
      shuffle_fields();
      step();
    end

    // random traffic: busy rare and ready sticky, so grants time out
    bus.req_busy = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 399) == 0) bus.req_ready[i] = ~bus.req_ready[i];
        if ($urandom_range(0, 799) == 0) bus.req_busy[i]  = 1'b1;
        else if ($urandom_range(0, 3) == 0) bus.req_busy[i] = 1'b0;
      end
      bus.tx_ack = 1'($urandom_range(0, 1));
      bus.tx_ws  = 1'($urandom_range(0, 1));
      step();
    end
    check("rand_timeouts_seen", (m_revokes > 0), 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
